// File: rtl/sequenciador.sv
// sequenciador: tiny accumulator sequencer that executes 8-bit instructions
// from an external 32-word program ROM.
//
// Instruction word: [7:4] opcode, [3:0] operand.
//   0 LOAD  1 ADD  2 SUB  3 OUT  4 JMP  5 JZ  6 WAIT  F HALT  others NOP
//
// Optional feature macro: SEQUENCIADOR_WAIT_EN
//   defined   -> opcode 6 with a non-zero operand stalls for that many cycles
//   undefined -> opcode 6 is a NOP; the WAIT state and its counter do not exist
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous active-high reset
//   inicio        start pulse, honoured only in IDLE or HALT
//   endereco[4:0] program ROM address (always the PC register)
//   dado[7:0]     ROM word, combinational from endereco
//   saida[7:0]    output register, written by OUT
//   saida_valida  high while a transfer is offered (state OUT)
//   saida_pronto  consumer ready
//   ocupado       high while executing (FETCH, EXEC, OUT, WAIT)
//   parado        high in HALT
module sequenciador (
  input  logic       clock,
  input  logic       reset,
  input  logic       inicio,
  output logic [4:0] endereco,
  input  logic [7:0] dado,
  output logic [7:0] saida,
  output logic       saida_valida,
  input  logic       saida_pronto,
  output logic       ocupado,
  output logic       parado
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT,
`ifdef SEQUENCIADOR_WAIT_EN
    S_WAIT,
`endif
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_LOAD = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_OUT  = 4'h3,
    OP_JMP  = 4'h4,
    OP_JZ   = 4'h5,
    OP_WAIT = 4'h6,
    OP_HALT = 4'hF
  } op_t;

  state_t     state, state_n;
  logic [4:0] pc, pc_n, pc_inc;
  logic [7:0] ir, ir_n;
  logic [7:0] acc, acc_n;
  logic [7:0] saida_n;
  logic [3:0] opcode, operand;
`ifdef SEQUENCIADOR_WAIT_EN
  logic [3:0] cont, cont_n;
`endif

  assign endereco = pc;
  assign opcode   = ir[7:4];
  assign operand  = ir[3:0];
  // 5-bit add wraps 31 -> 0 naturally.
  assign pc_inc   = pc + 5'd1;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    acc_n   = acc;
    saida_n = saida;
`ifdef SEQUENCIADOR_WAIT_EN
    cont_n  = cont;
`endif
    case (state)
      S_IDLE, S_HALT: begin
        if (inicio) begin
          pc_n    = '0;
          acc_n   = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_n    = dado;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        state_n = S_FETCH;
        pc_n    = pc_inc;
        case (opcode)
          OP_LOAD: acc_n = {4'b0, operand};
          OP_ADD:  acc_n = acc + {4'b0, operand};
          OP_SUB:  acc_n = acc - {4'b0, operand};
          OP_OUT: begin
            saida_n = acc;
            state_n = S_OUT;
          end
          OP_JMP:  pc_n = {1'b0, operand};
          OP_JZ: begin
            if (acc == '0) pc_n = {1'b0, operand};
          end
`ifdef SEQUENCIADOR_WAIT_EN
          OP_WAIT: begin
            // Zero-length wait degenerates to a NOP.
            if (operand != '0) begin
              cont_n  = operand;
              state_n = S_WAIT;
            end
          end
`endif
          OP_HALT: begin
            pc_n    = pc;
            state_n = S_HALT;
          end
          default: ;
        endcase
      end
      S_OUT: begin
        if (saida_pronto) state_n = S_FETCH;
      end
`ifdef SEQUENCIADOR_WAIT_EN
      S_WAIT: begin
        // Leaving on cont==1 yields exactly the loaded number of WAIT cycles.
        cont_n = cont - 4'd1;
        if (cont == 4'd1) state_n = S_FETCH;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with
  // the state register without any decode after the flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      ir           <= '0;
      acc          <= '0;
      saida        <= '0;
`ifdef SEQUENCIADOR_WAIT_EN
      cont         <= '0;
`endif
      saida_valida <= 1'b0;
      ocupado      <= 1'b0;
      parado       <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      ir           <= ir_n;
      acc          <= acc_n;
      saida        <= saida_n;
`ifdef SEQUENCIADOR_WAIT_EN
      cont         <= cont_n;
`endif
      saida_valida <= (state_n == S_OUT);
      ocupado      <= (state_n != S_IDLE) && (state_n != S_HALT);
      parado       <= (state_n == S_HALT);
    end
  end

endmodule

// File: tb/tb_sequenciador.sv
// Testbench for sequenciador: directed programs plus random programs, all
// checked cycle by cycle against an instruction-level reference model.
module tb_sequenciador;

  logic       clock = 1'b0;
  logic       reset, inicio, saida_pronto;
  logic [4:0] endereco;
  logic [7:0] dado, saida;
  logic       saida_valida, ocupado, parado;

  logic [7:0]  rom [32];
  logic        pronto_pat [200];
  logic [15:0] exp_q [$];
  logic [15:0] act [200];
  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;
  assign dado = rom[endereco];

  sequenciador dut (
    .clock(clock), .reset(reset), .inicio(inicio), .endereco(endereco),
    .dado(dado), .saida(saida), .saida_valida(saida_valida),
    .saida_pronto(saida_pronto), .ocupado(ocupado), .parado(parado)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] obs();
    return {ocupado, saida_valida, parado, endereco, saida};
  endfunction

  function automatic logic [15:0] pk(input bit busy, input bit valid, input bit halted,
                                     input int a, input int s);
    logic [4:0] a5;
    logic [7:0] s8;
    a5 = a[4:0];
    s8 = s[7:0];
    return {busy, valid, halted, a5, s8};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Instruction-level model: each instruction contributes its observed
  // cycles (fetch, execute, then any output/wait cycles) to exp_q.
  task automatic build_model(input int n);
    int pc, acc, sd, opc, op;
    logic [7:0] w;
    pc = 0; acc = 0; sd = 0;
    exp_q.delete();
    while (exp_q.size() < n) begin
      exp_q.push_back(pk(1, 0, 0, pc, sd));
      exp_q.push_back(pk(1, 0, 0, pc, sd));
      w = rom[pc];
      opc = int'(w[7:4]);
      op = int'(w[3:0]);
      case (opc)
        0: begin acc = op; pc = (pc + 1) % 32; end
        1: begin acc = (acc + op) % 256; pc = (pc + 1) % 32; end
        2: begin acc = (acc - op + 256) % 256; pc = (pc + 1) % 32; end
        3: begin
          sd = acc; pc = (pc + 1) % 32;
          do exp_q.push_back(pk(1, 1, 0, pc, sd));
          while (!pronto_pat[exp_q.size() - 1] && exp_q.size() < n);
        end
        4: pc = op;
        5: pc = (acc == 0) ? op : (pc + 1) % 32;
        6: begin
          pc = (pc + 1) % 32;
`ifdef SEQUENCIADOR_WAIT_EN
          repeat (op) exp_q.push_back(pk(1, 0, 0, pc, sd));
`endif
        end
        15: while (exp_q.size() < n) exp_q.push_back(pk(0, 0, 1, pc, sd));
        default: pc = (pc + 1) % 32;
      endcase
    end
  endtask

  // Reset, pulse inicio, then compare n cycles. inicio is held for 'hold'
  // extra cycles (must be ignored while busy). abort_at >= 0 applies reset
  // at that cycle and checks the block returns to a quiet IDLE.
  task automatic run(input string tag, input int n, input int hold, input int abort_at);
    build_model(n);
    reset = 1; inicio = 0; saida_pronto = 0;
    tick();
    reset = 0;
    chk({tag, " reset"}, obs(), 16'h0);
    inicio = 1;
    tick();
    for (int t = 0; t < n; t++) begin
      act[t] = obs();
      chk(tag, act[t], exp_q[t]);
      if (t == abort_at) begin
        reset = 1; inicio = 0;
        tick();
        reset = 0;
        chk({tag, " abort"}, obs(), 16'h0);
        repeat (3) begin
          tick();
          chk({tag, " idle after abort"}, obs(), 16'h0);
        end
        return;
      end
      saida_pronto = pronto_pat[t];
      inicio = (t < hold);
      tick();
    end
    inicio = 0;
  endtask

  function automatic int count_valid(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (act[i][14]) c++;
    return c;
  endfunction

  task automatic set_rom(input logic [7:0] fill);
    for (int i = 0; i < 32; i++) rom[i] = fill;
  endtask

  task automatic set_pronto(input logic v);
    for (int i = 0; i < 200; i++) pronto_pat[i] = v;
  endtask

  initial begin
    reset = 1; inicio = 0; saida_pronto = 0;
    set_rom(8'hF0);
    set_pronto(1'b1);

    // Scenario 1: LOAD 5, ADD 3, OUT, HALT.
    rom[0] = 8'h05; rom[1] = 8'h13; rom[2] = 8'h30; rom[3] = 8'hF0;
    run("s1", 14, 0, -1);
    chk("s1 valid cycles", 16'(count_valid(14)), 16'd1);
    chk("s1 saida", {8'h0, act[6][7:0]}, 16'h0008);
    chk("s1 halt at 9", {10'h0, act[9][13], act[9][12:8]}, {10'h0, 1'b1, 5'd3});

    // Same program with inicio held through FETCH/EXEC: must be ignored.
    run("s1 inicio held", 14, 3, -1);

    // Scenario 2: countdown 2,1,0 with JZ leaving the loop.
    set_rom(8'hF0);
    rom[0] = 8'h02; rom[1] = 8'h21; rom[2] = 8'h54; rom[3] = 8'h41; rom[4] = 8'hF0;
    run("s2", 18, 0, -1);
    chk("s2 halt addr4", {10'h0, act[14][13], act[14][12:8]}, {10'h0, 1'b1, 5'd4});
    chk("s2 acc", {8'h0, dut.acc}, 16'h0);

    // Scenario 3: OUT held off by saida_pronto low for 5 cycles.
    set_rom(8'hF0);
    rom[0] = 8'h07; rom[1] = 8'h30;
    for (int i = 4; i < 9; i++) pronto_pat[i] = 1'b0;
    run("s3", 14, 0, -1);
    chk("s3 valid cycles", 16'(count_valid(14)), 16'd6);
    chk("s3 last out", act[9], pk(1, 1, 0, 2, 7));
    chk("s3 after out", act[10], pk(1, 0, 0, 2, 7));
    set_pronto(1'b1);

    // Scenario 4: WAIT 4 (NOP when the feature is compiled out).
    set_rom(8'hF0);
    rom[0] = 8'h64;
    run("s4", 12, 0, -1);
`ifdef SEQUENCIADOR_WAIT_EN
    chk("s4 wait busy", act[5], pk(1, 0, 0, 1, 0));
    chk("s4 refetch", act[6], pk(1, 0, 0, 1, 0));
    chk("s4 halt", {15'h0, act[8][13]}, 16'h1);
    chk("s4 not halted early", {15'h0, act[7][13]}, 16'h0);
`else
    chk("s4 nop halt", {15'h0, act[4][13]}, 16'h1);
    chk("s4 nop next addr", {11'h0, act[2][12:8]}, 16'd1);
`endif

    // Scenario 5: all NOPs, PC wraps 31 -> 0.
    set_rom(8'h70);
    run("s5", 70, 0, -1);
    chk("s5 addr31", {11'h0, act[62][12:8]}, 16'd31);
    chk("s5 wrap", {11'h0, act[64][12:8]}, 16'd0);

    // SUB 1 from zero wraps to 0xFF.
    set_rom(8'hF0);
    rom[0] = 8'h21; rom[1] = 8'h30;
    run("s5 sub", 10, 0, -1);
    chk("s5 sub ff", act[4], pk(1, 1, 0, 2, 8'hFF));

    // Scenario 6: reset mid-OUT and mid-WAIT.
    set_rom(8'hF0);
    rom[0] = 8'h05; rom[1] = 8'h30;
    set_pronto(1'b0);
    run("s6 out", 12, 0, 6);
    set_rom(8'hF0);
    rom[0] = 8'h6F;
    run("s6 wait", 12, 0, 4);
    set_pronto(1'b1);

    // Random programs with random consumer backpressure.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) begin
        rom[i] = 8'($urandom);
        if (rom[i][7:4] == 4'hF && $urandom_range(0, 3) != 0) rom[i][7:4] = 4'h7;
      end
      for (int i = 0; i < 200; i++) pronto_pat[i] = ($urandom_range(0, 3) != 0);
      run("rand", 150, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
